bus_slave_mem: RTL and testbench

- Wait-state word-addressed memory slave.
- Sits directly downstream of the round-robin arbiter and consumes its slave bus: add_bus, byte_en, wr_bus, rd_bus, data_bus_wr, cpu_bus.
- Returns data_bus_rd and a one-cycle ack_bus pulse per transaction.
- Enforces a CPU-only write-protected region and counts protocol/access violations for the testbench scoreboard.

---
 rtl/bus_slave_mem_if.sv | 23 ++
 rtl/bus_slave_mem.sv | 172 +++++++++++++++++
 tb/tb_bus_slave_mem.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_mem_if.sv
// Slave-side bus bundle between the round-robin arbiter and bus_slave_mem.
// The arbiter (or a testbench) drives the request side; the memory answers
// with read data and a one-cycle acknowledge.
interface bus_slave_mem_if;
    logic [31:0] add_bus;
    logic [3:0]  byte_en;
    logic        wr_bus;
    logic        rd_bus;
    logic [31:0] data_bus_wr;
    logic        cpu_bus;
    logic [31:0] data_bus_rd;
    logic        ack_bus;

    modport master (
        output add_bus, byte_en, wr_bus, rd_bus, data_bus_wr, cpu_bus,
        input  data_bus_rd, ack_bus
    );

    modport slave (
        input  add_bus, byte_en, wr_bus, rd_bus, data_bus_wr, cpu_bus,
        output data_bus_rd, ack_bus
    );
endinterface

// File: rtl/bus_slave_mem.sv
// Wait-state word-addressed memory slave.
// A request is captured in IDLE, held for WAIT_STATES cycles, acknowledged
// for one cycle and followed by a single recovery cycle. Words below
// PROT_WORDS accept writes only from the CPU. Out-of-range accesses,
// protection hits and simultaneous read/write requests are counted in a
// saturating violation counter. DEPTH must be at least 2.
module bus_slave_mem #(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2,
    parameter int          PROT_WORDS  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    bus_slave_mem_if.slave  bus,
    output logic [15:0]     viol_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RECOVER
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;

    // Request payload captured at the accepting edge.
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        is_wr_q;
    logic        wr_ok_q;
    logic        viol_q;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data;
    logic [15:0] viol_count;

    logic        req;
    logic        capture;
    logic        enter_ack;
    logic        leave_ack;

    // While idle the live bus is decoded so a zero-wait read can be served
    // on the capture edge; afterwards only the latched request matters.
    logic [31:0] cur_addr;
    logic [31:0] cur_diff;
    logic [31:0] cur_idx;
    logic        cur_wr;
    logic        cur_oor;
    logic        cur_prot;
    logic [IDX_W-1:0] widx;

    assign req       = bus.rd_bus | bus.wr_bus;
    assign capture   = (state == ST_IDLE) && req;
    assign enter_ack = (state_next == ST_ACK) && (state != ST_ACK);
    assign leave_ack = (state == ST_ACK);

    assign cur_addr  = (state == ST_IDLE) ? bus.add_bus : addr_q;
    assign cur_wr    = (state == ST_IDLE) ? bus.wr_bus  : is_wr_q;
    assign cur_diff  = cur_addr - ADDR_BASE;
    assign cur_idx   = cur_diff >> 2;
    assign cur_oor   = (cur_idx >= 32'(DEPTH));
    assign cur_prot  = (cur_idx < 32'(PROT_WORDS)) && !bus.cpu_bus;
    assign widx      = cur_idx[IDX_W-1:0];

    assign rd_data   = cur_oor ? 32'hDEAD_BEEF : mem[widx];

    assign bus.ack_bus = (state == ST_ACK);
    assign viol_cnt    = viol_count;

    // State and wait counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic: wait countdown with abort on dropped request.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_ACK;
                    end else begin
                        state_next = ST_WAIT;
                        count_next = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_next = ST_IDLE;
                end else begin
                    count_next = 4'(count - 4'd1);
                    if (count == 4'd1) begin
                        state_next = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_next = ST_RECOVER;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the request payload and its access classification at capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q  <= bus.add_bus;
            be_q    <= bus.byte_en;
            wdata_q <= bus.data_bus_wr;
            is_wr_q <= bus.wr_bus;
            wr_ok_q <= bus.wr_bus && !cur_oor && !cur_prot;
            viol_q  <= cur_oor
                       || (bus.wr_bus && cur_prot)
                       || (bus.wr_bus && bus.rd_bus);
        end
    end

    // Read data: loaded entering ACK for reads, cleared when ACK ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_bus_rd <= '0;
        end else if (enter_ack && !cur_wr) begin
            bus.data_bus_rd <= rd_data;
        end else if (leave_ack) begin
            bus.data_bus_rd <= '0;
        end
    end

    // Memory array: cleared by reset, lane-masked write commit leaving ACK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (leave_ack && wr_ok_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Saturating violation counter, at most one step per transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol_count <= '0;
        end else if (leave_ack && viol_q && (viol_count != 16'hFFFF)) begin
            viol_count <= viol_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench for bus_slave_mem: directed scenarios plus randomized
// traffic compared against an array-based reference of the memory, its
// access rules and the saturating violation count.
module tb_bus_slave_mem;

    localparam int          DEPTH = 256;
    localparam int          WS    = 2;
    localparam int          PROT  = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] viol_cnt;

    bus_slave_mem_if bus();

    bus_slave_mem #(
        .DEPTH       (DEPTH),
        .ADDR_BASE   (BASE),
        .WAIT_STATES (WS),
        .PROT_WORDS  (PROT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .viol_cnt (viol_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m [DEPTH];
    int unsigned viol_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        viol_m = 0;
    endtask

    task automatic model_bump();
        if (viol_m < 32'hFFFF) viol_m++;
    endtask

    // One complete transaction: drive, check ack latency and read data,
    // check the post-ack cycle, then wait out the recovery cycle.
    task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data,
                          input logic cpu, input string tag,
                          output logic [31:0] got);
        logic [31:0] idx;
        logic [31:0] exp_rd;
        bit          oor, prot, viol, seen;
        int          lat;
        got = '0;
        @(negedge clk);
        bus.wr_bus = wr;  bus.rd_bus = rd;  bus.add_bus = addr;
        bus.byte_en = be; bus.data_bus_wr = data; bus.cpu_bus = cpu;
        idx  = (addr - BASE) >> 2;
        oor  = (idx >= DEPTH);
        prot = (idx < PROT) && !cpu;
        seen = 0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.ack_bus) begin
                seen = 1;
                lat  = k;
                got  = bus.data_bus_rd;
            end else begin
                // Payload changes after capture must be ignored.
                bus.add_bus     = $urandom();
                bus.data_bus_wr = $urandom();
                bus.byte_en     = 4'($urandom());
                bus.cpu_bus     = 1'($urandom());
            end
        end
        check({tag, " ack_latency"}, 32'(lat), 32'(WS + 1));
        bus.wr_bus = 1'b0;
        bus.rd_bus = 1'b0;
        if (wr) begin
            viol = oor || rd || prot;
            if (!oor && !prot) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem_m[idx][8*i +: 8] = data[8*i +: 8];
            end
        end else begin
            viol   = oor;
            exp_rd = oor ? 32'hDEAD_BEEF : mem_m[idx];
            check({tag, " rd_data"}, got, exp_rd);
        end
        if (viol) model_bump();
        @(posedge clk);
        #1;
        check({tag, " ack_after"}, 32'(bus.ack_bus), 32'd0);
        check({tag, " rd_after"}, bus.data_bus_rd, 32'd0);
        check({tag, " viol_cnt"}, 32'(viol_cnt), viol_m);
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] ra;
        int          op;
        bit          seen;

        bus.wr_bus = 0; bus.rd_bus = 0; bus.add_bus = 0;
        bus.byte_en = 0; bus.data_bus_wr = 0; bus.cpu_bus = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset ack", 32'(bus.ack_bus), 32'd0);
        check("reset rd_data", bus.data_bus_rd, 32'd0);
        check("reset viol", 32'(viol_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic write then read.
        do_txn(1, 0, 32'h100, 4'hF, 32'hA5A5_1234, 0, "t1_wr", got);
        do_txn(0, 1, 32'h100, 4'h0, 32'h0, 0, "t1_rd", got);
        check("t1 const", got, 32'hA5A5_1234);

        // Partial write on lanes 0 and 2.
        do_txn(1, 0, 32'h104, 4'hF, 32'h1122_3344, 0, "t2_init", got);
        do_txn(1, 0, 32'h104, 4'b0101, 32'hFFFF_FFFF, 0, "t2_part", got);
        do_txn(0, 1, 32'h104, 4'hF, 32'h0, 0, "t2_rd", got);
        check("t2 const", got, 32'h11FF_33FF);

        // Protected region.
        do_txn(1, 0, 32'h8, 4'hF, 32'hDEAD_0001, 0, "t3_wr_nocpu", got);
        do_txn(0, 1, 32'h8, 4'hF, 32'h0, 0, "t3_rd0", got);
        check("t3 blocked", got, 32'h0);
        check("t3 viol1", 32'(viol_cnt), 32'd1);
        do_txn(1, 0, 32'h8, 4'hF, 32'hDEAD_0001, 1, "t3_wr_cpu", got);
        do_txn(0, 1, 32'h8, 4'hF, 32'h0, 0, "t3_rd1", got);
        check("t3 allowed", got, 32'hDEAD_0001);
        check("t3 viol_hold", 32'(viol_cnt), 32'd1);

        // Out of range and simultaneous read/write.
        do_txn(0, 1, 32'h400, 4'hF, 32'h0, 0, "t4_oor", got);
        check("t4 deadbeef", got, 32'hDEAD_BEEF);
        check("t4 viol2", 32'(viol_cnt), 32'd2);
        do_txn(1, 1, 32'h10, 4'hF, 32'h7, 1, "t4_both", got);
        check("t4 viol3", 32'(viol_cnt), 32'd3);
        do_txn(0, 1, 32'h10, 4'hF, 32'h0, 0, "t4_rd", got);
        check("t4 both_wrote", got, 32'h7);

        // Zero byte enables: acked, nothing changes, no violation.
        do_txn(1, 0, 32'h100, 4'h0, 32'h0BAD_F00D, 0, "be0_wr", got);
        do_txn(0, 1, 32'h100, 4'hF, 32'h0, 0, "be0_rd", got);
        check("be0 unchanged", got, 32'hA5A5_1234);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            ra = 32'($urandom_range(0, 299)) * 4 + 32'($urandom_range(0, 3));
            op = $urandom_range(0, 3);
            do_txn((op <= 1) || (op == 3), (op >= 2), ra, 4'($urandom()),
                   $urandom(), 1'($urandom()), "rand", got);
        end

        // Abort: drop the request after capture.
        @(negedge clk);
        bus.rd_bus = 1; bus.add_bus = 32'h400;
        @(posedge clk);
        #1;
        check("abort ack_cap", 32'(bus.ack_bus), 32'd0);
        @(negedge clk);
        bus.rd_bus = 0;
        for (int k = 0; k < 1; k++) begin
            @(posedge clk);
            #1;
            check("abort ack_none", 32'(bus.ack_bus), 32'd0);
        end
        do_txn(0, 1, 32'h104, 4'hF, 32'h0, 0, "abort_next", got);
        check("abort no_viol", 32'(viol_cnt), viol_m);

        // Reset during the ack of a write.
        @(negedge clk);
        bus.wr_bus = 1; bus.rd_bus = 0; bus.add_bus = 32'h14;
        bus.byte_en = 4'hF; bus.data_bus_wr = 32'hCAFE_0005; bus.cpu_bus = 1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.ack_bus) seen = 1;
        end
        check("rst reached_ack", 32'(seen), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst ack_clear", 32'(bus.ack_bus), 32'd0);
        check("rst rd_clear", bus.data_bus_rd, 32'd0);
        check("rst viol_clear", 32'(viol_cnt), 32'd0);
        @(negedge clk);
        bus.wr_bus = 0;
        reset_n = 1'b1;
        model_reset();
        do_txn(0, 1, 32'h14, 4'hF, 32'h0, 0, "rst_rd", got);
        check("rst no_commit", got, 32'h0);
        do_txn(0, 1, 32'h104, 4'hF, 32'h0, 0, "rst_mem_clr", got);
        check("rst mem_cleared", got, 32'h0);

        // Saturation via backdoor preload plus violations.
        @(negedge clk);
        dut.viol_count = 16'hFFFB;
        viol_m = 32'hFFFB;
        for (int n = 0; n < 3; n++)
            do_txn(0, 1, 32'h800, 4'hF, 32'h0, 0, "sat_pre", got);
        check("sat fffe", 32'(viol_cnt), 32'hFFFE);
        for (int n = 0; n < 2; n++)
            do_txn(1, 0, 32'h4, 4'hF, 32'h1, 0, "sat_post", got);
        check("sat ffff", 32'(viol_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
